// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-granular round-robin arbiter onto one 64-bit MAC TX stream.
// Define ETH_TX_ARB_STATS_EN to add per-source frame counters and a gap-cycle total.
module eth_tx_arb #(
   parameter int NUM_SRC = 4,
   parameter int GAP_W   = 16
) (
   input  logic                  clk156,
   input  logic                  sys_rst_n,
   input  logic                  enable,
   input  logic [GAP_W-1:0]      ifg_cycles,
   input  logic [NUM_SRC-1:0]    s_axis_tvalid,
   output logic [NUM_SRC-1:0]    s_axis_tready,
   input  logic [NUM_SRC*64-1:0] s_axis_tdata,
   input  logic [NUM_SRC*8-1:0]  s_axis_tkeep,
   input  logic [NUM_SRC-1:0]    s_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [63:0]           m_axis_tdata,
   output logic [7:0]            m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
`ifdef ETH_TX_ARB_STATS_EN
   input  logic                  stats_clr,
   output logic [NUM_SRC*32-1:0] frame_cnt,
   output logic [31:0]           gap_cycles_total,
`endif
   output logic [2:0]            grant_idx,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FRAME = 2'd1,
      ARB_GAP   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_grant;
   logic [2:0]       w_grant_nxt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [GAP_W-1:0] w_gap_nxt;
   logic             w_found;
   logic [2:0]       w_win;
   logic             w_eof;

   // Round-robin search: first valid source k steps past the last grant.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_grant;
      for (int k = 1; k <= NUM_SRC; k++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && s_axis_tvalid[i] &&
                r_grant == 3'((i - k + NUM_SRC) % NUM_SRC)) begin
               w_found = 1'b1;
               w_win   = 3'(i);
            end
         end
      end
   end

   // Combinational data/ready path from the granted source while in a frame.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (r_state == ARB_FRAME) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == 3'(i)) begin
               m_axis_tvalid    = s_axis_tvalid[i];
               m_axis_tdata     = s_axis_tdata[i*64 +: 64];
               m_axis_tkeep     = s_axis_tkeep[i*8 +: 8];
               m_axis_tlast     = s_axis_tlast[i];
               s_axis_tready[i] = m_axis_tready;
            end
         end
      end
   end

   assign w_eof = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Next-state logic: grant in IDLE, hold to tlast, then optional idle gap.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gap_nxt   = r_gap_cnt;
      unique case (r_state)
         ARB_IDLE: begin
            if (enable && w_found) begin
               w_grant_nxt = w_win;
               w_state_nxt = ARB_FRAME;
            end
         end
         ARB_FRAME: begin
            if (w_eof) begin
               if (ifg_cycles == '0) begin
                  w_state_nxt = ARB_IDLE;
               end else begin
                  w_gap_nxt   = ifg_cycles - GAP_W'(1);
                  w_state_nxt = ARB_GAP;
               end
            end
         end
         ARB_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = ARB_IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt - GAP_W'(1);
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // State, grant and gap registers; last-grant resets so source 0 wins first.
   always_ff @(posedge clk156) begin
      if (!sys_rst_n) begin
         r_state   <= ARB_IDLE;
         r_grant   <= 3'(NUM_SRC - 1);
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_gap_cnt <= w_gap_nxt;
      end
   end

   assign grant_idx    = r_grant;
   assign busy         = (r_state == ARB_FRAME) || (r_state == ARB_GAP);
   assign m_axis_tuser = 1'b0;

`ifdef ETH_TX_ARB_STATS_EN
   logic [NUM_SRC-1:0]       w_src_eof;
   logic                     w_in_gap;
   logic [NUM_SRC-1:0][31:0] r_frame_cnt;
   logic [31:0]              r_gap_total;

   assign w_src_eof = s_axis_tready & s_axis_tvalid & s_axis_tlast;
   assign w_in_gap  = (r_state == ARB_GAP);

   // Frame and gap statistics; a clear coinciding with an event leaves 1.
   always_ff @(posedge clk156) begin
      if (!sys_rst_n) begin
         r_frame_cnt <= '0;
         r_gap_total <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (stats_clr) begin
               r_frame_cnt[i] <= {31'd0, w_src_eof[i]};
            end else if (w_src_eof[i]) begin
               r_frame_cnt[i] <= r_frame_cnt[i] + 32'd1;
            end
         end
         if (stats_clr) begin
            r_gap_total <= {31'd0, w_in_gap};
         end else if (w_in_gap) begin
            r_gap_total <= r_gap_total + 32'd1;
         end
      end
   end

   assign frame_cnt        = r_frame_cnt;
   assign gap_cycles_total = r_gap_total;
`else
   // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed self-checking bench for eth_tx_arb (NUM_SRC=4).
// Source model emits beats {DA7A, src, beat}; tkeep 0F on the tlast beat.
`timescale 1ns/1ps
module tb_eth_tx_arb;
   localparam int NS = 4;

   logic            clk156 = 1'b0;
   logic            sys_rst_n;
   logic            enable;
   logic [15:0]     ifg_cycles;
   logic [NS-1:0]   s_axis_tvalid;
   logic [NS-1:0]   s_axis_tready;
   logic [NS*64-1:0] s_axis_tdata;
   logic [NS*8-1:0] s_axis_tkeep;
   logic [NS-1:0]   s_axis_tlast;
   logic            m_axis_tready;
   logic            m_axis_tvalid;
   logic [63:0]     m_axis_tdata;
   logic [7:0]      m_axis_tkeep;
   logic            m_axis_tlast;
   logic            m_axis_tuser;
   logic [2:0]      grant_idx;
   logic            busy;
`ifdef ETH_TX_ARB_STATS_EN
   logic            stats_clr;
   logic [NS*32-1:0] frame_cnt;
   logic [31:0]     gap_cycles_total;
`endif

   int checks = 0;
   int errors = 0;

   logic [NS-1:0] src_on;
   logic [NS-1:0] one_shot;
   int            src_len [NS];
   int            beat [NS];

   eth_tx_arb #(.NUM_SRC(NS), .GAP_W(16)) dut (
      .clk156(clk156), .sys_rst_n(sys_rst_n), .enable(enable),
      .ifg_cycles(ifg_cycles),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tlast(s_axis_tlast), .m_axis_tready(m_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser),
`ifdef ETH_TX_ARB_STATS_EN
      .stats_clr(stats_clr), .frame_cnt(frame_cnt),
      .gap_cycles_total(gap_cycles_total),
`endif
      .grant_idx(grant_idx), .busy(busy)
   );

   always #5 clk156 = ~clk156;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic drive_srcs();
      for (int i = 0; i < NS; i++) begin
         s_axis_tvalid[i]         = src_on[i];
         s_axis_tdata[i*64 +: 64] = {16'hDA7A, 16'(i), 32'(beat[i])};
         s_axis_tkeep[i*8 +: 8]   = (beat[i] == src_len[i] - 1) ? 8'h0F : 8'hFF;
         s_axis_tlast[i]          = (beat[i] == src_len[i] - 1);
      end
   endtask

   task automatic tick();
      logic [NS-1:0] hs;
      logic [NS-1:0] lst;
      hs  = s_axis_tvalid & s_axis_tready;
      lst = hs & s_axis_tlast;
      @(posedge clk156);
      for (int i = 0; i < NS; i++) begin
         if (lst[i]) begin
            beat[i] = 0;
            if (one_shot[i]) src_on[i] = 1'b0;
         end else if (hs[i]) begin
            beat[i] = beat[i] + 1;
         end
      end
      #1 drive_srcs();
      #1;
   endtask

   task automatic do_reset();
      src_on = '0;
      one_shot = '0;
      for (int i = 0; i < NS; i++) begin
         beat[i] = 0;
         src_len[i] = 2;
      end
      drive_srcs();
      enable = 1'b1;
      ifg_cycles = 16'd0;
      m_axis_tready = 1'b1;
`ifdef ETH_TX_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      sys_rst_n = 1'b0;
      tick();
      tick();
      sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      sys_rst_n = 1'b0;
      src_on = '1;
      drive_srcs();
      tick();
      tick();
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
      checks++; if (m_axis_tkeep !== 8'd0) begin errors++; $display("FAIL reset_tkeep: got %h want 0", m_axis_tkeep); end
      checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
      checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b want 0", m_axis_tuser); end
      checks++; if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL reset_sready: got %b want 0000", s_axis_tready); end
      checks++; if (grant_idx !== 3'd3) begin errors++; $display("FAIL reset_grant: got %0d want 3", grant_idx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_single_frame();
      do_reset();
      src_len[0] = 3;
      one_shot[0] = 1'b1;
      src_on[0] = 1'b1;
      drive_srcs();
      #1;
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_req_tvalid: got %b want 0", m_axis_tvalid); end
      checks++; if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL single_req_sready: got %b want 0000", s_axis_tready); end
      tick();
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_b0_tvalid: got %b want 1", m_axis_tvalid); end
      checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL single_grant: got %0d want 0", grant_idx); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      checks++; if (s_axis_tready !== 4'b0001) begin errors++; $display("FAIL single_sready: got %b want 0001", s_axis_tready); end
      checks++; if (m_axis_tdata !== 64'hDA7A_0000_0000_0000) begin errors++; $display("FAIL single_b0_data: got %h want da7a000000000000", m_axis_tdata); end
      checks++; if (m_axis_tkeep !== 8'hFF || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL single_b0_keep: got %h/%b want ff/0", m_axis_tkeep, m_axis_tlast); end
      tick();
      checks++; if (m_axis_tdata !== 64'hDA7A_0000_0000_0001 || m_axis_tkeep !== 8'hFF) begin errors++; $display("FAIL single_b1: got %h/%h want da7a000000000001/ff", m_axis_tdata, m_axis_tkeep); end
      tick();
      checks++; if (m_axis_tdata !== 64'hDA7A_0000_0000_0002) begin errors++; $display("FAIL single_b2_data: got %h want da7a000000000002", m_axis_tdata); end
      checks++; if (m_axis_tkeep !== 8'h0F || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL single_b2_keep: got %h/%b want 0f/1", m_axis_tkeep, m_axis_tlast); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
      checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0) begin errors++; $display("FAIL single_idle_out: got %b/%h want 0/0", m_axis_tvalid, m_axis_tdata); end
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int exp_beat;
      do_reset();
      src_on = '1;
      drive_srcs();
      exp_beat = 0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         tick();
         if (m_axis_tvalid && m_axis_tready) begin
            checks++; if (m_axis_tdata[47:32] !== 16'(grant_idx)) begin errors++; $display("FAIL rr_src: got %0d want %0d", m_axis_tdata[47:32], grant_idx); end
            checks++; if (m_axis_tdata[31:0] !== 32'(exp_beat)) begin errors++; $display("FAIL rr_beat: got %0d want %0d", m_axis_tdata[31:0], exp_beat); end
            if (m_axis_tlast) begin
               order.push_back(int'(grant_idx));
               exp_beat = 0;
            end else begin
               exp_beat = 1;
            end
         end
      end
      checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_timeout: got %0d frames want 5", order.size()); end
      for (int k = 0; k < order.size() && k < 5; k++) begin
         checks++; if (order[k] != exp_order[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]); end
      end
   endtask

   task automatic test_gap();
      int c;
      do_reset();
      ifg_cycles = 16'd5;
      src_on[1] = 1'b1;
      drive_srcs();
      #1;
      c = 0;
      while (!(m_axis_tvalid && m_axis_tready && m_axis_tlast) && c < 20) begin
         tick();
         c++;
      end
      checks++; if (c >= 20) begin errors++; $display("FAIL gap_wait_tlast: got %0d cycles want <20", c); end
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 2) ifg_cycles = 16'd2;
         checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_cycle%0d: got tvalid=%b busy=%b want 0/1", k, m_axis_tvalid, busy); end
      end
      tick();
      checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL gap_grant_cycle: got tvalid=%b busy=%b want 0/0", m_axis_tvalid, busy); end
      tick();
      checks++; if (m_axis_tvalid !== 1'b1 || grant_idx !== 3'd1) begin errors++; $display("FAIL gap_next_frame: got tvalid=%b grant=%0d want 1/1", m_axis_tvalid, grant_idx); end
      checks++; if (m_axis_tdata !== 64'hDA7A_0001_0000_0000) begin errors++; $display("FAIL gap_next_data: got %h want da7a000100000000", m_axis_tdata); end
   endtask

   task automatic test_backpressure();
      bit [5:0] rp = 6'b100101;
      int eb [6] = '{0, 1, 1, 2, 2, 2};
      do_reset();
      src_len[2] = 3;
      one_shot[2] = 1'b1;
      src_on[2] = 1'b1;
      src_on[3] = 1'b1;
      drive_srcs();
      tick();
      for (int j = 0; j < 6; j++) begin
         m_axis_tready = rp[j];
         #1;
         checks++; if (s_axis_tready !== {1'b0, rp[j], 2'b00}) begin errors++; $display("FAIL bp_sready[%0d]: got %b want 0%b00", j, s_axis_tready, rp[j]); end
         checks++; if (m_axis_tdata !== {16'hDA7A, 16'd2, 32'(eb[j])}) begin errors++; $display("FAIL bp_data[%0d]: got %h want beat %0d", j, m_axis_tdata, eb[j]); end
         checks++; if (m_axis_tlast !== (eb[j] == 2) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_last[%0d]: got last=%b valid=%b", j, m_axis_tlast, m_axis_tvalid); end
         tick();
      end
      m_axis_tready = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || s_axis_tready !== 4'b0000) begin errors++; $display("FAIL bp_end: got busy=%b sready=%b want 0/0000", busy, s_axis_tready); end
   endtask

   task automatic test_enable();
      do_reset();
      src_len[3] = 3;
      one_shot[3] = 1'b1;
      src_on[3] = 1'b1;
      drive_srcs();
      tick();
      checks++; if (grant_idx !== 3'd3 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL en_grant3: got grant=%0d valid=%b want 3/1", grant_idx, m_axis_tvalid); end
      enable = 1'b0;
      src_len[0] = 2;
      one_shot[0] = 1'b1;
      src_on[0] = 1'b1;
      drive_srcs();
      #1;
      checks++; if (s_axis_tready !== 4'b1000) begin errors++; $display("FAIL en_sready: got %b want 1000", s_axis_tready); end
      tick();
      tick();
      checks++; if (m_axis_tlast !== 1'b1 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL en_completes: got last=%b valid=%b want 1/1", m_axis_tlast, m_axis_tvalid); end
      tick();
      checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL en_idle: got busy=%b valid=%b want 0/0", busy, m_axis_tvalid); end
      tick();
      tick();
      checks++; if (busy !== 1'b0 || grant_idx !== 3'd3) begin errors++; $display("FAIL en_held_off: got busy=%b grant=%0d want 0/3", busy, grant_idx); end
      enable = 1'b1;
      tick();
      checks++; if (grant_idx !== 3'd0 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL en_regrant: got grant=%0d valid=%b want 0/1", grant_idx, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 64'hDA7A_0000_0000_0000) begin errors++; $display("FAIL en_regrant_data: got %h want da7a000000000000", m_axis_tdata); end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      src_len[1] = 4;
      one_shot[1] = 1'b1;
      src_on[1] = 1'b1;
      drive_srcs();
      tick();
      tick();
      checks++; if (m_axis_tdata !== 64'hDA7A_0001_0000_0001) begin errors++; $display("FAIL rstmid_b1: got %h want da7a000100000001", m_axis_tdata); end
      sys_rst_n = 1'b0;
      tick();
      checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_out: got valid=%b last=%b want 0/0", m_axis_tvalid, m_axis_tlast); end
      checks++; if (grant_idx !== 3'd3 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got grant=%0d busy=%b want 3/0", grant_idx, busy); end
      checks++; if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rstmid_sready: got %b want 0000", s_axis_tready); end
      sys_rst_n = 1'b1;
   endtask

`ifdef ETH_TX_ARB_STATS_EN
   task automatic test_stats();
      int n;
      int c;
      do_reset();
      checks++; if (frame_cnt !== '0 || gap_cycles_total !== 32'd0) begin errors++; $display("FAIL stats_reset: got %h/%0d want 0/0", frame_cnt, gap_cycles_total); end
      ifg_cycles = 16'd2;
      src_on[1] = 1'b1;
      drive_srcs();
      #1;
      n = 0;
      c = 0;
      while (n < 4 && c < 60) begin
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            n++;
            if (n == 4) one_shot[1] = 1'b1;
         end
         tick();
         c++;
      end
      for (int k = 0; k < 4; k++) tick();
      checks++; if (frame_cnt[63:32] !== 32'd4) begin errors++; $display("FAIL stats_src1: got %0d want 4", frame_cnt[63:32]); end
      checks++; if (frame_cnt[31:0] !== 32'd0) begin errors++; $display("FAIL stats_src0: got %0d want 0", frame_cnt[31:0]); end
      checks++; if (gap_cycles_total !== 32'd8) begin errors++; $display("FAIL stats_gap: got %0d want 8", gap_cycles_total); end
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      checks++; if (frame_cnt !== '0 || gap_cycles_total !== 32'd0) begin errors++; $display("FAIL stats_clr: got %h/%0d want 0/0", frame_cnt, gap_cycles_total); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_round_robin();
      test_gap();
      test_backpressure();
      test_enable();
      test_reset_midframe();
`ifdef ETH_TX_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Frame-granular round-robin arbiter sharing one 10G MAC AXI-Stream TX port (64-bit, clk156 domain) between NUM_SRC packet generators.
- A grant is held from first beat to tlast, so frames never interleave.
- A programmable inter-frame idle gap is inserted after each frame for coarse rate control.
- Sits between the generator instances and the MAC TX interface on the vc709 board.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- GAP_W, 16, width of the gap counter and of the ifg_cycles input.

Ports:
- clk156  input  1  156.25 MHz clock; only clock.
- sys_rst_n  input  1  synchronous reset, active-low.
- enable  input  1  allows new grants; an in-progress frame always completes.
- ifg_cycles  input  GAP_W  idle cycles inserted after each frame; sampled on the tlast handshake.
- s_axis_tvalid  input  NUM_SRC  per-source tvalid.
- s_axis_tready  output  NUM_SRC  per-source tready.
- s_axis_tdata  input  NUM_SRC*64  per-source data; source i occupies [64i+63:64i].
- s_axis_tkeep  input  NUM_SRC*8  per-source tkeep.
- s_axis_tlast  input  NUM_SRC  per-source tlast.
- m_axis_tready  input  1  MAC tready.
- m_axis_tvalid  output  1  to MAC.
- m_axis_tdata  output  64  to MAC.
- m_axis_tkeep  output  8  to MAC.
- m_axis_tlast  output  1  to MAC.
- m_axis_tuser  output  1  tied 0.
- grant_idx  output  3  index of the current or last granted source.
- busy  output  1  high in ARB_FRAME or ARB_GAP.

Behaviour:
- Reset (sys_rst_n low at a clock edge):
  - State ARB_IDLE; grant_idx=NUM_SRC-1, so source 0 has first priority; gap_cnt=0.
  - All outputs 0.
  - Reset mid-frame abandons the frame immediately; no tlast is emitted.
- State ARB_IDLE:
  - m_axis_tvalid=0 and s_axis_tready=0.
  - If enable=1 and any s_axis_tvalid bit is set, the winner is the first set bit searching from grant_idx+1 upward, wrapping modulo NUM_SRC.
  - On a win, grant_idx is registered and the state goes to ARB_FRAME.
  - Grant latency is one cycle: the first beat can transfer in the cycle after the request is seen.
- State ARB_FRAME:
  - m_axis_tvalid/tdata/tkeep/tlast are combinationally muxed from source grant_idx.
  - s_axis_tready[grant_idx]=m_axis_tready; all other s_axis_tready bits are 0.
  - The ready path is combinational; no buffering, no added latency.
  - Non-granted tvalid is ignored, and the grant is held regardless of enable.
- End of frame (handshake with m_axis_tvalid & m_axis_tready & m_axis_tlast):
  - ifg_cycles==0: go to ARB_IDLE.
  - Otherwise: gap_cnt<=ifg_cycles-1 and go to ARB_GAP.
- State ARB_GAP:
  - Outputs are as in ARB_IDLE.
  - gap_cnt decrements each cycle; at gap_cnt==0 the state goes to ARB_IDLE.
  - ifg_cycles=N therefore produces exactly N cycles with tvalid low between the tlast beat and the earliest next grant cycle. The minimum frame-to-frame spacing is N+1 cycles because of the IDLE grant cycle.
- When tdata is not being driven (not in ARB_FRAME), m_axis_tdata and m_axis_tkeep are 0.
- Granted source drops tvalid mid-frame: the grant is held and m_axis_tvalid follows it low; the arbiter waits for tlast.
- A tlast beat with m_axis_tready=0 is not an end of frame; the beat is held.
- ifg_cycles changes mid-gap: no effect on the gap in progress.
- Single requester: it is re-granted after every gap, so back-to-back frames from one source are allowed.
- Invalid state encoding: go to ARB_IDLE.

Optional Feature:
- Macro: ETH_TX_ARB_STATS_EN.
- When defined:
  - Adds outputs frame_cnt, NUM_SRC*32 bits; one counter per source, incremented on that source's tlast handshake.
  - Counters wrap modulo 2^32 and clear on reset or when the new input stats_clr=1.
  - If stats_clr and an increment happen in the same cycle, the counter becomes 1.
  - Also adds gap_cycles_total, 32 bits, incremented every cycle in ARB_GAP and cleared the same way.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, enable=1, ifg_cycles=0, source 0 only sends a 3-beat frame (tkeep FF,FF,0F) with m_axis_tready=1:
  - Grant occurs one cycle after s_axis_tvalid[0] rises; m_axis passes 3 beats identical to source 0.
  - grant_idx=0; busy drops the cycle after tlast.
- All 4 sources continuously valid with 2-beat frames, ifg_cycles=0 → grant order is 0,1,2,3,0; no beat from two sources ever interleaves.
- ifg_cycles=5, source 1 continuous → exactly 5 cycles with m_axis_tvalid=0 after each tlast, then a 1-cycle grant, next frame; busy high during the gap.
- m_axis_tready toggles 1,0,1,0 during a frame from source 2 → s_axis_tready[2] mirrors m_axis_tready each cycle; the tlast beat holds until ready=1; other readies stay 0.
- enable deasserted mid-frame from source 3 → frame completes to tlast; no new grant while enable=0; after enable=1 the next grant goes to source 0 if valid.
- sys_rst_n pulsed low on the 2nd beat of a frame → next cycle m_axis_tvalid=0 and grant_idx=3. With ETH_TX_ARB_STATS_EN, frame_cnt is 0 after reset and equals 4 for source 1 after 4 completed frames.
